// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_e     : transmitter FSM states
//   DEF_PAT_W   : default pattern length in bits
//   DEF_PATTERN : default pattern, sent MSB first
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int                   DEF_PAT_W   = 6;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 6'b101010;

endpackage

// File: rtl/seq_bit_ctr.sv
// Loadable down-counter. The same module serves as the pattern bit index
// and as the repetition counter.
//   clk        : clock
//   rst        : asynchronous active-low reset, count returns to RST_VAL
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; saturates at zero so it can never wrap
//   count      : registered count
//   count_next : value the count takes at the next edge
//   zero       : count == 0
module seq_bit_ctr
    import seq_pkg::*;
#(
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= RST_VAL;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter. On an accepted start it shifts PATTERN out
// MSB first, one bit per clock, reps times (0 counts as 1), optionally with
// one idle cycle between repetitions, then pulses done for one cycle.
//   clk     : clock
//   rst     : asynchronous active-low reset
//   start   : transmission request, accepted only while ready
//   reps    : repetition count, sampled on accept
//   gap     : insert one idle cycle between repetitions, sampled on accept
//   abort   : synchronous cancel from any state, no done pulse
//   ready   : state is IDLE (combinational)
//   n       : serial data bit (registered)
//   n_valid : n carries a pattern bit (registered)
//   done    : one-cycle pulse after the last bit (registered)
module seq_gen
    import seq_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    input  logic             gap,
    input  logic             abort,
    output logic             ready,
    output logic             n,
    output logic             n_valid,
    output logic             done
);

    localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    state_e state_reg, state_next;
    logic   gap_reg, gap_next;
    logic   n_reg, n_next;
    logic   n_valid_reg, n_valid_next;
    logic   done_reg, done_next;

    logic             idx_load, idx_dec, idx_zero;
    logic [IDX_W-1:0] idx_count, idx_next;
    logic             rep_load, rep_dec, rep_zero;
    logic [CNT_W-1:0] rep_count, rep_next, reps_eff;
    logic             last_rep;

    assign reps_eff = (reps == '0) ? CNT_W'(1) : reps;
    // rep_zero is only reachable if the counter were somehow empty; treating
    // it as "last" keeps a stray zero from ever turning into a long run.
    assign last_rep = (rep_count == CNT_W'(1)) || rep_zero;

    seq_bit_ctr #(
        .W       (IDX_W),
        .RST_VAL (IDX_TOP)
    ) u_idx_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (idx_load),
        .load_val   (IDX_TOP),
        .dec        (idx_dec),
        .count      (idx_count),
        .count_next (idx_next),
        .zero       (idx_zero)
    );

    seq_bit_ctr #(
        .W       (CNT_W),
        .RST_VAL ('0)
    ) u_rep_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (rep_load),
        .load_val   (reps_eff),
        .dec        (rep_dec),
        .count      (rep_count),
        .count_next (rep_next),
        .zero       (rep_zero)
    );

    // Counter views not needed by this FSM.
    logic unused_ok;
    assign unused_ok = ^{idx_count, rep_next};

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        idx_load   = 1'b0;
        idx_dec    = 1'b0;
        rep_load   = 1'b0;
        rep_dec    = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = SEND;
                        gap_next   = gap;
                        idx_load   = 1'b1;
                        rep_load   = 1'b1;
                    end
                end
                SEND: begin
                    if (!idx_zero) begin
                        idx_dec = 1'b1;
                    end else if (last_rep) begin
                        state_next = DONE;
                    end else begin
                        rep_dec    = 1'b1;
                        idx_load   = 1'b1;
                        state_next = gap_reg ? GAP : SEND;
                    end
                end
                GAP:     state_next = SEND;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and next index so that they
    // appear registered in the same cycle the FSM enters that state.
    always_comb begin
        n_valid_next = (state_next == SEND);
        n_next       = (state_next == SEND) ? PATTERN[idx_next] : 1'b0;
        done_next    = (state_next == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            gap_reg     <= 1'b0;
            n_reg       <= 1'b0;
            n_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gap_reg     <= gap_next;
            n_reg       <= n_next;
            n_valid_reg <= n_valid_next;
            done_reg    <= done_next;
        end
    end

    assign ready   = (state_reg == IDLE);
    assign n       = n_reg;
    assign n_valid = n_valid_reg;
    assign done    = done_reg;

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter: on a start handshake, emits a fixed PAT_W-bit pattern MSB-first, one bit per clock, repeated a programmable number of times, with an optional idle bit between repetitions. It is the stimulus/transmit end of the serial bit-stream interface consumed by the sequence detectors (e.g. the 101010 detector `sd`). It drives their 1-bit serial input directly, so a detector sampling on the same `clk` sees each bit for exactly one cycle.

## Interface
- PAT_W, 6, pattern length in bits (≥2)
- PATTERN, 6'b101010, pattern transmitted MSB (bit PAT_W-1) first
- CNT_W, 4, width of the repetition count
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request a transmission; accepted only when `ready`=1
- reps  in  CNT_W  number of pattern repetitions; sampled on accept; 0 treated as 1
- gap  in  1  1 = insert one idle cycle between repetitions; sampled on accept
- abort  in  1  synchronous cancel, any state
- ready  out  1  high in IDLE only
- n  out  1  serial data bit (registered)
- n_valid  out  1  high while `n` carries a pattern bit (registered)
- done  out  1  one-cycle pulse after the last bit of the last repetition (registered)

## Operation
- States: IDLE, SEND, GAP, DONE.
- Reset (`rst`=0, immediate, any state): state=IDLE, n=0, n_valid=0, done=0, ready=1, bit index=PAT_W-1, rep counter=0.
- IDLE: n=0, n_valid=0. If start=1 at an edge:
  - latch rep_cnt = (reps==0 ? 1 : reps) and gap_q = gap;
  - set idx = PAT_W-1;
  - go to SEND.
- SEND: n=PATTERN[idx], n_valid=1. Each edge:
  - if idx≠0: idx−1;
  - else if rep_cnt==1: go to DONE;
  - else: rep_cnt−1, idx=PAT_W-1, go to GAP if gap_q else stay in SEND (back-to-back patterns, no bubble).
- GAP: n=0, n_valid=0 for exactly one cycle, then SEND.
- DONE: done=1, n_valid=0, n=0, ready=0 for one cycle, then IDLE.
- start while not IDLE: ignored, with no effect on latched values.
- abort=1 at an edge: next state IDLE, n/n_valid cleared, no done pulse. Abort has priority over start and over all other transitions.
- reps changing after accept: no effect on the transmission in progress.
- Arithmetic:
  - idx is clog2(PAT_W) bits and must never exceed PAT_W-1;
  - rep_cnt is CNT_W bits and only decrements; no wrap-around is possible.

## Timing
- Start accepted at edge E0 ⇒ bit i (i=0 is the MSB) valid in the cycle following edge E0+i.
- Bits per run: reps_eff·PAT_W. Total SEND+GAP cycles: reps_eff·PAT_W + gap·(reps_eff−1).
- done is high in the cycle right after the last valid bit. ready returns 1 the following cycle.
- Minimum start-to-start spacing: transmission length + 2 cycles (DONE, then IDLE accept).
- `ready` is a combinational decode of state==IDLE. All other outputs are flop outputs.

## Structure
- Package `seq_pkg`:
  - state enum {IDLE, SEND, GAP, DONE};
  - constant DEF_PATTERN = 6'b101010;
  - constant DEF_PAT_W = 6.
- Sub-module `seq_bit_ctr`: loadable down-counter holding idx, with load, decrement and zero-flag outputs. It is reused for rep_cnt by instantiating it twice with different widths.
- Top: FSM plus output registers.

## Test plan
- Reset: assert rst=0 in the middle of SEND (bit 3) → n=0, n_valid=0, done=0, ready=1 at once. After release, the block idles until start.
- start with reps=1, gap=0 → n = 1,0,1,0,1,0 with n_valid=1 for 6 cycles; done=1 in cycle 7; ready=1 in cycle 8.
- reps=2, gap=1 → 101010, one cycle with n_valid=0 and n=0, then 101010; 13 cycles total; then a single done.
- reps=0 → identical to reps=1: 6 valid bits, one done. reps=15, gap=0 → 90 consecutive valid bits with no bubble.
- start pulsed during SEND → ignored, bit count unchanged. abort at bit index 2 → IDLE next cycle, n_valid=0, no done, ready=1. An immediate restart then works normally.
- Loopback into the `sd` detector with reps=1, gap=0 → detector output asserts in the cycle after the 6th bit is sampled. A run with PATTERN=6'b101011 → detector output never asserts.
